// File: rtl/mc_ctrl_pkg.sv
// Shared types and select encodings for the multicycle controller.
// The ALU-op values are also consumed by the ALU function decoder.
package mc_ctrl_pkg;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_J     = 6'b000010,
      OP_BEQ   = 6'b000100,
      OP_ADDI  = 6'b001000,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011
   } opcode_e;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMRD    = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWR    = 4'd6,
      S_EXECUTE  = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_ADDIEXEC = 4'd10,
      S_ADDIWB   = 4'd11,
      S_JUMP     = 4'd12,
      S_ILLEGAL  = 4'd13
   } state_e;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic [1:0] aluop;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic       iord;
      logic       regdst;
      logic       memtoreg;
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic       regwrite;
      logic       memwrite;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/mc_out_dec.sv
// State-to-control-word decode for the multicycle controller.
// Purely combinational; only the fetch write strobes look at mem_ready.
module mc_out_dec
   import mc_ctrl_pkg::*;
(
   input  state_e state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.alusrcb = SRCB_FOUR;
            ctrl.aluop   = ALUOP_ADD;
            ctrl.irwrite = mem_ready;
            ctrl.pcwrite = mem_ready;
         end
         S_DECODE: begin
            ctrl.alusrcb = SRCB_IMMSH;
            ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEXEC: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
         end
         S_MEMRD: ctrl.iord = 1'b1;
         S_MEMWB: begin
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         S_MEMWR: begin
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = ALUOP_SUB;
            ctrl.pcsrc   = PCSRC_ALUOUT;
            ctrl.branch  = 1'b1;
         end
         S_ADDIWB: ctrl.regwrite = 1'b1;
         S_JUMP: begin
            ctrl.pcsrc   = PCSRC_JUMP;
            ctrl.pcwrite = 1'b1;
         end
         S_ILLEGAL: ctrl.illegal = 1'b1;
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_main_fsm.sv
// Main multicycle control FSM: state register, next-state decode and
// retired-instruction counter; control word comes from mc_out_dec.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | after reset, all controls low
// FETCH    | read instruction, PC+4; waits on mem_ready
// DECODE   | register read, branch target precompute
// MEMADR   | load/store address compute
// MEMRD    | load data read; waits on mem_ready
// MEMWB    | load data to register file
// MEMWR    | store write; waits on mem_ready
// EXECUTE  | R-type ALU operation
// ALUWB    | R-type result to rd
// BRANCH   | compare and conditional PC load
// ADDIEXEC | immediate add
// ADDIWB   | immediate result to rt
// JUMP     | PC load from jump target
// ILLEGAL  | one-cycle flag, instruction skipped
module mc_main_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [5:0]       i_op,
   input  logic             i_mem_ready,
   output logic [1:0]       o_aluop,
   output logic             o_alusrca,
   output logic [1:0]       o_alusrcb,
   output logic [1:0]       o_pcsrc,
   output logic             o_iord,
   output logic             o_regdst,
   output logic             o_memtoreg,
   output logic             o_irwrite,
   output logic             o_pcwrite,
   output logic             o_branch,
   output logic             o_regwrite,
   output logic             o_memwrite,
   output logic             o_illegal,
   output logic [CNT_W-1:0] o_retired
);

   state_e state;
   ctrl_t  ctrl;
   logic   retire;

   // An illegal opcode never counts as a completed instruction.
   always_comb begin
      retire = (state inside {S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP})
               || ((state == S_MEMWR) && i_mem_ready);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= S_IDLE;
         o_retired <= '0;
      end else begin
         case (state)
            S_IDLE:   state <= S_FETCH;
            S_FETCH:  if (i_mem_ready) state <= S_DECODE;
            S_DECODE: begin
               case (i_op)
                  OP_LW, OP_SW: state <= S_MEMADR;
                  OP_RTYPE:     state <= S_EXECUTE;
                  OP_BEQ:       state <= S_BRANCH;
                  OP_ADDI:      state <= S_ADDIEXEC;
                  OP_J:         state <= S_JUMP;
                  default:      state <= S_ILLEGAL;
               endcase
            end
            S_MEMADR:   state <= (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (i_mem_ready) state <= S_MEMWB;
            S_MEMWB:    state <= S_FETCH;
            S_MEMWR:    if (i_mem_ready) state <= S_FETCH;
            S_EXECUTE:  state <= S_ALUWB;
            S_ALUWB:    state <= S_FETCH;
            S_BRANCH:   state <= S_FETCH;
            S_ADDIEXEC: state <= S_ADDIWB;
            S_ADDIWB:   state <= S_FETCH;
            S_JUMP:     state <= S_FETCH;
            S_ILLEGAL:  state <= S_FETCH;
            default:    state <= S_FETCH;
         endcase
         if (retire) o_retired <= o_retired + CNT_W'(1);
      end
   end

   mc_out_dec u_out_dec (
      .state     (state),
      .mem_ready (i_mem_ready),
      .ctrl      (ctrl)
   );

   assign o_aluop    = ctrl.aluop;
   assign o_alusrca  = ctrl.alusrca;
   assign o_alusrcb  = ctrl.alusrcb;
   assign o_pcsrc    = ctrl.pcsrc;
   assign o_iord     = ctrl.iord;
   assign o_regdst   = ctrl.regdst;
   assign o_memtoreg = ctrl.memtoreg;
   assign o_irwrite  = ctrl.irwrite;
   assign o_pcwrite  = ctrl.pcwrite;
   assign o_branch   = ctrl.branch;
   assign o_regwrite = ctrl.regwrite;
   assign o_memwrite = ctrl.memwrite;
   assign o_illegal  = ctrl.illegal;

endmodule

// File: doc/mc_main_fsm.md
Name: mc_main_fsm

Overview:
Main control state machine for the multicycle datapath. Decodes the instruction opcode over several cycles and drives every datapath enable and mux select, including the 2-bit ALU-op code consumed by the ALU function decoder. Sits in the Controller beside the ALU decoder, replacing the single-cycle main decoder. Adds a memory-ready stall handshake and a retired-instruction counter.

Parameters:
CNT_W, 16, width of the retired-instruction counter

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_op  in  6  opcode field of the instruction register
i_mem_ready  in  1  memory has completed the current access this cycle
o_aluop  out  2  00 add, 01 subtract, 10 use funct
o_alusrca  out  1  0 PC, 1 register A
o_alusrcb  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
o_pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
o_iord  out  1  memory address: 0 PC, 1 ALUOut
o_regdst  out  1  0 rt, 1 rd
o_memtoreg  out  1  0 ALUOut, 1 data register
o_irwrite  out  1  instruction register load
o_pcwrite  out  1  unconditional PC load
o_branch  out  1  PC load qualified by ALU zero (ANDed downstream)
o_regwrite  out  1  register file write
o_memwrite  out  1  memory write request
o_illegal  out  1  one-cycle pulse on an unsupported opcode
o_retired  out  CNT_W  count of completed instructions, wraps

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010. All others are illegal.
- Outputs are Moore, decoded from the state only, except that o_irwrite and o_pcwrite in FETCH are ANDed with i_mem_ready.
- Any output not listed for a state is 0.
- Reset (async assert) forces state IDLE and o_retired=0. In IDLE every output is 0. IDLE always goes to FETCH on the next clock.
- Reset asserted mid-instruction abandons the instruction; no partial write may be asserted while i_rst_n=0.
- States, outputs, and transitions:
  - FETCH: alusrcb=01, aluop=00, irwrite=pcwrite=i_mem_ready. Stays while i_mem_ready=0; goes to DECODE when it is 1.
  - DECODE: alusrcb=11, aluop=00. LW/SW -> MEMADR; RTYPE -> EXECUTE; BEQ -> BRANCH; ADDI -> ADDIEXEC; J -> JUMP; other -> ILLEGAL.
  - MEMADR: alusrca=1, alusrcb=10. LW -> MEMRD; SW -> MEMWR.
  - MEMRD: iord=1. Holds until i_mem_ready=1, then goes to MEMWB.
  - MEMWB: memtoreg=1, regwrite=1 -> FETCH.
  - MEMWR: iord=1, memwrite=1. memwrite is held until i_mem_ready=1, then goes to FETCH.
  - EXECUTE: alusrca=1, aluop=10 -> ALUWB.
  - ALUWB: regdst=1, regwrite=1 -> FETCH.
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1 -> FETCH.
  - ADDIEXEC: alusrca=1, alusrcb=10 -> ADDIWB.
  - ADDIWB: regwrite=1 -> FETCH.
  - JUMP: pcsrc=10, pcwrite=1 -> FETCH.
  - ILLEGAL: illegal=1 -> FETCH. The PC was already advanced in FETCH, so the instruction is skipped.
- o_retired increments by 1 on the rising edge that leaves any of these: MEMWB, MEMWR (with i_mem_ready=1), ALUWB, BRANCH, ADDIWB, JUMP.
  - It does not increment for ILLEGAL.
  - At all-ones it wraps to 0.
- i_op is sampled only in DECODE and MEMADR. The IR is stable from DECODE onward because o_irwrite=0 there.
- Instruction latency with i_mem_ready=1 throughout:
  - LW: 5 cycles
  - SW, RTYPE, ADDI: 4 cycles
  - BEQ, J: 3 cycles
- Unreachable state encodings go to FETCH.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - opcode enum (RTYPE, LW, SW, BEQ, ADDI, J)
  - state enum (IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, ILLEGAL)
  - aluop constants (ADD=00, SUB=01, FUNCT=10), shared with the ALU decoder
  - alusrcb and pcsrc select constants
- Sub-module mc_out_dec: purely combinational state-to-control-word decode. The FSM proper keeps the state register, next-state logic, and the counter.

Test Plan:
- Reset release, i_mem_ready=1, i_op=RTYPE:
  - Cycle 0 (IDLE): all outputs 0.
  - FETCH: pcwrite=1, irwrite=1.
  - Then DECODE, EXECUTE (aluop=10), ALUWB (regwrite=1, regdst=1).
  - o_retired goes 0->1 after ALUWB.
- LW with i_mem_ready low for 3 cycles in MEMRD:
  - iord=1 held for 4 cycles.
  - MEMWB asserts memtoreg=1, regwrite=1.
  - Total 8 cycles.
  - FETCH with ready low: pcwrite=irwrite=0 and state holds.
- SW: memwrite=1 and iord=1 held until ready. No regwrite in any cycle. o_retired increments once.
- BEQ then J:
  - BRANCH: aluop=01, branch=1, pcsrc=01, pcwrite=0.
  - JUMP: pcsrc=10, pcwrite=1.
  - 3 cycles each.
- i_op=111111: DECODE -> ILLEGAL with o_illegal=1 for exactly 1 cycle, back to FETCH, o_retired unchanged.
- Counter and reset:
  - Preload via 2^CNT_W-1 instructions (CNT_W=4): 15 -> 0 wrap.
  - Assert i_rst_n mid-MEMWR: memwrite drops to 0 immediately (async), state IDLE, o_retired=0.
